// File: rtl/alu_ctrl_fsm.sv
// alu_ctrl_fsm: multicycle ALU/datapath controller; instr valid/ready in, leu/mem_ack in; selector0-4, reg_we/mem_re/mem_we, pc_sel, link_we, done/illegal/timeout pulses, retired count out
module alu_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [31:0]      instr,
  input  logic             leu,
  input  logic             mem_ack,
  output logic             selector0,
  output logic             selector1,
  output logic             selector2,
  output logic             selector3,
  output logic             selector4,
  output logic             reg_we,
  output logic             mem_re,
  output logic             mem_we,
  output logic [1:0]       pc_sel,
  output logic             link_we,
  output logic             done,
  output logic             illegal,
  output logic             timeout,
  output logic [CNT_W-1:0] retired
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, WB, TRAP} state_t;
  typedef enum logic [3:0] {
    OP_ADD, OP_LW, OP_SW, OP_NOR, OP_NORI, OP_NOT, OP_ROLV, OP_RORV,
    OP_JR, OP_JAL, OP_BLEU, OP_ILL
  } op_t;
  state_t state, state_n;
  op_t op, op_d;
  logic [3:0] op_bits;
  logic [WW-1:0] wait_cnt;
  logic done_q;
  logic ctrl;
  logic [2:0] sel;
  logic unused_bits;
  assign unused_bits = ^instr[25:6];
  always_comb begin
    op_d = OP_ILL;
    case (instr[31:26])
      6'b000000:
        case (instr[5:0])
          6'b100000: op_d = OP_ADD;
          6'b100111: op_d = OP_NOR;
          6'b000100: op_d = OP_ROLV;
          6'b000110: op_d = OP_RORV;
          6'b001000: op_d = OP_JR;
          default:   op_d = OP_ILL;
        endcase
      6'b100011: op_d = OP_LW;
      6'b101011: op_d = OP_SW;
      6'b001110: op_d = OP_NORI;
      6'b010000: op_d = OP_NOT;
      6'b000011: op_d = OP_JAL;
      6'b000111: op_d = OP_BLEU;
      default:   op_d = OP_ILL;
    endcase
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = instr_valid && instr_ready ? DECODE : IDLE;
      DECODE:  state_n = op == OP_ILL ? TRAP : EXEC;
      EXEC:    state_n = (op == OP_LW || op == OP_SW) ? MEM : ctrl ? IDLE : WB;
      MEM:     state_n = mem_ack ? (op == OP_LW ? WB : IDLE) :
                         wait_cnt == WW'(MEM_TIMEOUT) ? TRAP : MEM;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op       <= OP_ADD;
      wait_cnt <= WW'(1);
      done_q   <= 1'b0;
      retired  <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= state == MEM ? wait_cnt + 1'b1 : WW'(1);
      done_q   <= (state == MEM && mem_ack && op == OP_SW) || (state == WB && op == OP_LW);
      retired  <= retired + CNT_W'(done);
      if (state == IDLE && instr_valid && instr_ready) op <= op_d;
    end
  end
  // Memory ops retire one cycle after leaving MEM/WB; done_q carries that
  // pulse and keeps the unit closed to new work while it is shown.
  assign instr_ready = state == IDLE && !done_q;
  assign ctrl        = op == OP_JR || op == OP_JAL || op == OP_BLEU;
  assign op_bits     = op;
  assign sel         = (state == IDLE || ctrl || op == OP_ILL) ? 3'd0 : op_bits[2:0];
  assign {selector4, selector3} = 2'b00;
  assign {selector2, selector1, selector0} = sel;
  assign reg_we  = state == WB;
  assign mem_re  = state == MEM && op == OP_LW;
  assign mem_we  = state == MEM && op == OP_SW;
  assign pc_sel  = state != EXEC ? 2'b00 : op == OP_JR ? 2'b10 : op == OP_JAL ? 2'b11 :
                   op == OP_BLEU ? {1'b0, leu} : 2'b00;
  assign link_we = state == EXEC && op == OP_JAL;
  assign done    = (state == EXEC && ctrl) || (state == WB && op != OP_LW) || done_q;
  assign illegal = state == TRAP && op == OP_ILL;
  assign timeout = state == TRAP && op != OP_ILL;
endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// tb_alu_ctrl_fsm: directed and random instruction streams checked against a latency-table model
module tb_alu_ctrl_fsm;
  localparam int CW = 4;
  localparam int TMO = 15;
  localparam int ADD = 0, LW = 1, SW = 2, NOR = 3, NORI = 4, NOT = 5, ROLV = 6, RORV = 7;
  localparam int JR = 8, JAL = 9, BLEU = 10, ILL = 11, ILL63 = 12;
  localparam logic [9:0] IDLE_V = 10'b10_0000_0000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic instr_valid = 1'b0;
  logic leu = 1'b0;
  logic mem_ack = 1'b0;
  logic [31:0] instr = '0;
  logic instr_ready, selector0, selector1, selector2, selector3, selector4;
  logic reg_we, mem_re, mem_we, link_we, done, illegal, timeout;
  logic [1:0] pc_sel;
  logic [CW-1:0] retired;
  logic [9:0] outs;
  logic [4:0] sels;
  int checks = 0;
  int failures = 0;
  int exp_ret = 0;
  alu_ctrl_fsm #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .leu(leu), .mem_ack(mem_ack),
    .selector0(selector0), .selector1(selector1), .selector2(selector2),
    .selector3(selector3), .selector4(selector4),
    .reg_we(reg_we), .mem_re(mem_re), .mem_we(mem_we), .pc_sel(pc_sel),
    .link_we(link_we), .done(done), .illegal(illegal), .timeout(timeout), .retired(retired)
  );
  always #5 clk = ~clk;
  assign outs = {instr_ready, reg_we, mem_re, mem_we, pc_sel, link_we, done, illegal, timeout};
  assign sels = {selector4, selector3, selector2, selector1, selector0};
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  function automatic bit is_alu(input int kind);
    return kind == ADD || kind == NOR || kind == NORI || kind == NOT || kind == ROLV || kind == RORV;
  endfunction
  function automatic logic [2:0] code(input int kind);
    case (kind)
      LW: return 3'd1;
      SW: return 3'd2;
      NOR: return 3'd3;
      NORI: return 3'd4;
      NOT: return 3'd5;
      ROLV: return 3'd6;
      RORV: return 3'd7;
      default: return 3'd0;
    endcase
  endfunction
  function automatic logic [31:0] encode(input int kind);
    logic [31:0] w;
    w = $urandom();
    case (kind)
      ADD:  w = {6'b000000, w[25:6], 6'b100000};
      NOR:  w = {6'b000000, w[25:6], 6'b100111};
      ROLV: w = {6'b000000, w[25:6], 6'b000100};
      RORV: w = {6'b000000, w[25:6], 6'b000110};
      JR:   w = {6'b000000, w[25:6], 6'b001000};
      LW:   w = {6'b100011, w[25:0]};
      SW:   w = {6'b101011, w[25:0]};
      NORI: w = {6'b001110, w[25:0]};
      NOT:  w = {6'b010000, w[25:0]};
      JAL:  w = {6'b000011, w[25:0]};
      BLEU: w = {6'b000111, w[25:0]};
      ILL63: w[31:26] = 6'b111111;
      default: begin
        if ($urandom_range(1) == 1) begin
          w[31:26] = 6'b000000;
          while (w[5:0] inside {6'd32, 6'd39, 6'd4, 6'd6, 6'd8}) w[5:0] = 6'($urandom());
        end else begin
          while (w[31:26] inside {6'd0, 6'd35, 6'd43, 6'd14, 6'd16, 6'd3, 6'd7}) w[31:26] = 6'($urandom());
        end
      end
    endcase
    return w;
  endfunction
  function automatic int last_cycle(input int kind, input int k);
    if (kind == JR || kind == JAL || kind == BLEU || kind >= ILL) return 2;
    if (is_alu(kind)) return 3;
    if (k > TMO) return 3 + TMO;
    return kind == SW ? 3 + k : 4 + k;
  endfunction
  // Expected outputs c cycles after the accept edge, from the documented latencies.
  function automatic logic [9:0] model(input int kind, input int k, input int c, input logic l);
    bit mem, to;
    int ms;
    logic rw, mr, mw, lk, dn, il, tm;
    logic [1:0] ps;
    mem = kind == LW || kind == SW;
    to = mem && k > TMO;
    ms = to ? TMO : k;
    mr = kind == LW && c >= 3 && c <= 2 + ms;
    mw = kind == SW && c >= 3 && c <= 2 + ms;
    rw = (is_alu(kind) && c == 3) || (kind == LW && !to && c == 3 + k);
    dn = ((kind == JR || kind == JAL || kind == BLEU) && c == 2) || (is_alu(kind) && c == 3) ||
         (kind == SW && !to && c == 3 + k) || (kind == LW && !to && c == 4 + k);
    ps = 2'b00;
    if (c == 2) ps = kind == JR ? 2'b10 : kind == JAL ? 2'b11 : kind == BLEU ? {1'b0, l} : 2'b00;
    lk = kind == JAL && c == 2;
    il = kind >= ILL && c == 2;
    tm = to && c == 3 + TMO;
    return {1'b0, rw, mr, mw, ps, lk, dn, il, tm};
  endfunction
  task automatic run(input int kind, input int k, input int gap, input int leu_sel, input int abort_at);
    logic [31:0] w;
    logic [9:0] e;
    int last, sel_end, ms;
    bit mem;
    w = encode(kind);
    last = last_cycle(kind, k);
    mem = kind == LW || kind == SW;
    ms = k > TMO ? TMO : k;
    sel_end = mem && k <= TMO ? last - 1 : last;
    for (int g = 0; g < gap; g++) begin
      instr_valid = 1'b0;
      instr = $urandom();
      leu = 1'($urandom_range(1));
      mem_ack = 1'($urandom_range(1));
      #1;
      chk("idle_outs", outs, IDLE_V);
      chk("idle_retired", retired, exp_ret % (1 << CW));
      @(negedge clk);
    end
    for (int c = 0; c <= last; c++) begin
      instr_valid = c == 0 ? 1'b1 : 1'($urandom_range(1));
      instr = c == 0 ? w : $urandom();
      leu = (c == 2 && leu_sel >= 0) ? leu_sel[0] : 1'($urandom_range(1));
      mem_ack = (mem && c >= 3 && c <= 2 + ms) ? (c == 2 + k) : 1'($urandom_range(1));
      #1;
      e = c == 0 ? IDLE_V : model(kind, k, c, leu);
      chk($sformatf("outs kind=%0d k=%0d c=%0d", kind, k, c), outs, e);
      chk($sformatf("retired kind=%0d c=%0d", kind, c), retired, exp_ret % (1 << CW));
      if (c >= 1 && c <= sel_end && kind < ILL)
        chk($sformatf("sel kind=%0d c=%0d", kind, c), sels, {2'b00, code(kind)});
      if (e[2]) exp_ret++;
      if (c == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_outs", outs, IDLE_V);
        chk("rst_mid_sel", sels, 0);
        chk("rst_mid_retired", retired, 0);
        exp_ret = 0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask
  initial begin
    #1;
    chk("reset_outs", outs, IDLE_V);
    chk("reset_sel", sels, 0);
    chk("reset_retired", retired, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(ADD, 0, 0, -1, -1);
    run(RORV, 0, 0, -1, -1);
    run(NORI, 0, 0, -1, -1);
    run(LW, 3, 1, -1, -1);
    run(SW, 1, 0, -1, -1);
    run(SW, 16, 0, -1, -1);
    run(LW, 16, 1, -1, -1);
    run(ILL63, 0, 0, -1, -1);
    run(ILL, 0, 0, -1, -1);
    run(BLEU, 0, 0, 1, -1);
    run(BLEU, 0, 0, 0, -1);
    run(JAL, 0, 0, -1, -1);
    run(JR, 0, 0, -1, -1);
    run(LW, 15, 0, -1, -1);
    run(SW, 15, 0, -1, -1);
    run(LW, 16, 0, -1, 5);
    run(NOT, 0, 0, -1, -1);
    run(NOR, 0, 2, -1, -1);
    run(ROLV, 0, 0, -1, -1);
    for (int i = 0; i < 80; i++)
      run(int'($urandom_range(0, 11)), int'($urandom_range(1, 16)), int'($urandom_range(0, 2)), -1, -1);
    run(SW, 7, 0, -1, 6);
    run(ADD, 0, 1, -1, -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
